snow64_bfloat16_mul: RTL and testbench

Sequential BFloat16 multiplier, the execution stage that consumes the shared BinOp command interface (start, a, b) and produces the shared Oper result interface (data_valid, can_accept_cmd, data). Format: 1 sign bit, 8-bit exponent (bias 127), 7-bit stored mantissa. The block uses the two-state multiply FSM (StMulIdle, StMulFinishing) from the BFloat16 package. It sits beside the add and div units under the vector FPU dispatch.

---
 rtl/snow64_bfloat16_mul.sv | 132 +++++++++++++
 tb/tb_snow64_bfloat16_mul.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_bfloat16_mul.sv
// Two-cycle BFloat16 multiplier: operands are classified and multiplied on
// accept, then normalized, rounded and range-checked on the finishing cycle.
module snow64_bfloat16_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_start,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_data_valid,
    output logic        out_can_accept_cmd,
    output logic [15:0] out_data
);

    typedef enum logic {
        StMulIdle,
        StMulFinishing
    } state_t;

    state_t state, state_next;

    logic               r_sign;
    logic               r_a_zero, r_a_inf, r_a_nan;
    logic               r_b_zero, r_b_inf, r_b_nan;
    logic [15:0]        r_prod;
    logic signed [9:0]  r_exp;

    logic [7:0] ea, eb;
    logic [6:0] ma, mb;
    logic       accept;

    assign ea = in_a[14:7];
    assign eb = in_b[14:7];
    assign ma = in_a[6:0];
    assign mb = in_b[6:0];
    assign accept = (state == StMulIdle) && in_start;
    assign out_can_accept_cmd = (state == StMulIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StMulIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            StMulIdle:      if (in_start) state_next = StMulFinishing;
            StMulFinishing: state_next = StMulIdle;
            default:        state_next = StMulIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_a_zero <= 1'b0;
            r_a_inf  <= 1'b0;
            r_a_nan  <= 1'b0;
            r_b_zero <= 1'b0;
            r_b_inf  <= 1'b0;
            r_b_nan  <= 1'b0;
            r_prod   <= 16'h0000;
            r_exp    <= 10'sd0;
        end else if (accept) begin
            r_sign   <= in_a[15] ^ in_b[15];
            r_a_zero <= (ea == 8'h00);
            r_a_inf  <= (ea == 8'hFF) && (ma == 7'h00);
            r_a_nan  <= (ea == 8'hFF) && (ma != 7'h00);
            r_b_zero <= (eb == 8'h00);
            r_b_inf  <= (eb == 8'hFF) && (mb == 7'h00);
            r_b_nan  <= (eb == 8'hFF) && (mb != 7'h00);
            r_prod   <= {8'h00, 1'b1, ma} * {8'h00, 1'b1, mb};
            r_exp    <= $signed({2'b00, ea}) + $signed({2'b00, eb})
                        - 10'sd127;
        end
    end

    logic              hi;
    logic [6:0]        mant;
    logic              guard, sticky, round_up;
    logic [7:0]        mant_r;
    logic [6:0]        mant_f;
    logic signed [9:0] exp_n, exp_f;
    logic              any_nan, any_inf, any_zero;
    logic [15:0]       result;

    // Product of two [1,2) significands lies in [1,4); bit 15 marks >= 2.
    assign hi       = r_prod[15];
    assign mant     = hi ? r_prod[14:8] : r_prod[13:7];
    assign guard    = hi ? r_prod[7] : r_prod[6];
    assign sticky   = hi ? (|r_prod[6:0]) : (|r_prod[5:0]);
    assign round_up = guard & (sticky | mant[0]);
    assign mant_r   = {1'b0, mant} + {7'h00, round_up};
    assign exp_n    = r_exp + (hi ? 10'sd1 : 10'sd0);
    assign exp_f    = mant_r[7] ? (exp_n + 10'sd1) : exp_n;
    assign mant_f   = mant_r[7] ? 7'h00 : mant_r[6:0];

    assign any_nan  = r_a_nan | r_b_nan
                    | (r_a_inf & r_b_zero) | (r_b_inf & r_a_zero);
    assign any_inf  = r_a_inf | r_b_inf;
    assign any_zero = r_a_zero | r_b_zero;

    always_comb begin
        result = {r_sign, exp_f[7:0], mant_f};
        if (any_nan) begin
            result = 16'h7FC0;
        end else if (any_inf) begin
            result = {r_sign, 8'hFF, 7'h00};
        end else if (any_zero) begin
            result = {r_sign, 15'h0000};
        end else if (exp_f >= 10'sd255) begin
            result = {r_sign, 8'hFF, 7'h00};
        end else if (exp_f <= 10'sd0) begin
            result = {r_sign, 15'h0000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_valid <= 1'b0;
            out_data       <= 16'h0000;
        end else if (state == StMulFinishing) begin
            out_data_valid <= 1'b1;
            out_data       <= result;
        end else begin
            out_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snow64_bfloat16_mul.sv
// Scoreboard bench for snow64_bfloat16_mul: a double-precision reference
// model predicts each product; a monitor checks data, latency and handshake.
module tb_snow64_bfloat16_mul;

    logic        clk;
    logic        rst_n;
    logic        in_start;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_data_valid;
    logic        out_can_accept_cmd;
    logic [15:0] out_data;

    snow64_bfloat16_mul dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_start          (in_start),
        .in_a              (in_a),
        .in_b              (in_b),
        .out_data_valid    (out_data_valid),
        .out_can_accept_cmd(out_can_accept_cmd),
        .out_data          (out_data)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] want;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   valid_seen = 0;
    logic busy;
    exp_t e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference: multiply significands exactly as a real, let IEEE double
    // normalize it, then round the double's fraction to 7 bits (RNE).
    function automatic logic [15:0] ref_mul(input logic [15:0] a,
                                            input logic [15:0] b);
        logic        s;
        int          ea, eb, ma, mb, de, m, e2, mr;
        bit          az, ai, an, bz, bi, bn, g, st;
        real         x;
        logic [63:0] bits;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        ma = int'(a[6:0]);  mb = int'(b[6:0]);
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 255 && ma == 0); bi = (eb == 255 && mb == 0);
        an = (ea == 255 && ma != 0); bn = (eb == 255 && mb != 0);
        if (an || bn || (ai && bz) || (bi && az)) return 16'h7FC0;
        if (ai || bi) return {s, 8'hFF, 7'h00};
        if (az || bz) return {s, 15'h0000};
        x    = real'((128 + ma) * (128 + mb));
        bits = $realtobits(x);
        de   = int'(bits[62:52]) - 1023;
        m    = int'(bits[51:45]);
        g    = bits[44];
        st   = |bits[43:0];
        e2   = ea + eb - 127 + (de - 14);
        mr   = m + ((g && (st || m[0])) ? 1 : 0);
        if (mr == 128) begin
            mr = 0;
            e2 = e2 + 1;
        end
        if (e2 >= 255) return {s, 8'hFF, 7'h00};
        if (e2 <= 0) return {s, 15'h0000};
        return {s, e2[7:0], mr[6:0]};
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] ex;
        int         k;
        k = int'($urandom_range(0, 9));
        if (k == 0) ex = 8'h00;
        else if (k == 1) ex = 8'hFF;
        else ex = 8'($urandom_range(64, 190));
        return {1'($urandom_range(0, 1)), ex, 7'($urandom_range(0, 127))};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            busy = (q.size() > 0) && (cycle == q[0].cyc + 1);
            checks++;
            if (out_can_accept_cmd !== !busy) begin
                errors++;
                $display("FAIL can_accept cyc=%0d got %b want %b",
                         cycle, out_can_accept_cmd, !busy);
            end
            if (out_data_valid === 1'b1) begin
                valid_seen++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d data=%h",
                             cycle, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.want) begin
                        errors++;
                        $display("FAIL product a=%h b=%h got %h want %h",
                                 e.a, e.b, out_data, e.want);
                    end
                    checks++;
                    if (cycle != e.cyc + 2) begin
                        errors++;
                        $display("FAIL latency a=%h b=%h got %0d want %0d",
                                 e.a, e.b, cycle - e.cyc, 2);
                    end
                end
            end
        end
    end

    // Drive at #1 after the falling edge; push only if it will be accepted.
    task automatic drive(input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] want,
                         output bit taken);
        exp_t x;
        @(negedge clk);
        #1;
        in_start = st;
        in_a     = a;
        in_b     = b;
        taken    = st && out_can_accept_cmd;
        if (taken) begin
            x.a = a; x.b = b; x.want = want; x.cyc = cycle;
            q.push_back(x);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] want);
        bit taken;
        taken = 1'b0;
        for (int i = 0; i < 4 && !taken; i++) drive(1'b1, a, b, want, taken);
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL send_timeout a=%h b=%h got busy want accepted",
                     a, b);
        end
    endtask

    task automatic idle_drain();
        bit taken;
        drive(1'b0, 16'h0, 16'h0, 16'h0, taken);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        bit          taken;
        int          accepted;
        int          v0;
        logic [15:0] a, b;
        rst_n    = 1'b0;
        in_start = 1'b0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_data_valid !== 1'b0 || out_can_accept_cmd !== 1'b1
            || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got %b/%b/%h want 0/1/0000",
                     out_data_valid, out_can_accept_cmd, out_data);
        end
        rst_n = 1'b1;

        send(16'h3F80, 16'h3F80, 16'h3F80);
        idle_drain();
        send(16'h3FC0, 16'h3FC0, 16'h4010);
        send(16'hC000, 16'h4040, 16'hC0C0);
        send(16'h3FFF, 16'h3FFF, 16'h407E);
        send(16'h3F83, 16'h3FC0, 16'h3FC4);
        send(16'h3F85, 16'h3FC0, 16'h3FC8);
        send(16'h7F00, 16'h7F00, 16'h7F80);
        send(16'h0080, 16'h0080, 16'h0000);
        send(16'h0000, 16'hC000, 16'h8000);
        send(16'h7F80, 16'h0000, 16'h7FC0);
        send(16'hFF80, 16'h4000, 16'hFF80);
        send(16'h7FC1, 16'h3F80, 16'h7FC0);
        idle_drain();

        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            a = rand_bf();
            b = rand_bf();
            drive(1'b1, a, b, ref_mul(a, b), taken);
            if (taken) accepted++;
        end
        idle_drain();
        checks++;
        if (accepted != 20) begin
            errors++;
            $display("FAIL stream_accepts got %0d want 20", accepted);
        end

        for (int i = 0; i < 300; i++) begin
            a = rand_bf();
            b = rand_bf();
            drive($urandom_range(0, 2) != 0, a, b, ref_mul(a, b), taken);
        end
        idle_drain();

        send(16'h4040, 16'h4040, 16'h4110);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if (out_data_valid !== 1'b0 || out_can_accept_cmd !== 1'b1
            || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL midop_reset got %b/%b/%h want 0/1/0000",
                     out_data_valid, out_can_accept_cmd, out_data);
        end
        in_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_seen;
        repeat (5) @(negedge clk);
        checks++;
        if (valid_seen != v0) begin
            errors++;
            $display("FAIL post_reset_pulse got %0d want 0", valid_seen - v0);
        end
        send(16'h4000, 16'h4000, 16'h4080);
        idle_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
